// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for a DDS: steps the tuning word from start to stop
// in clamped increments, dwelling a fixed number of cycles per value, optionally repeating.
module dds_sweep_ctrl #(
    parameter int unsigned TW = 8,
    parameter int unsigned PW = 12,
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [TW-1:0] cfg_start_tw,
    input  logic [TW-1:0] cfg_stop_tw,
    input  logic [TW-1:0] cfg_step_tw,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [CW-1:0] cfg_sweeps,
    input  logic [PW-1:0] cfg_phase,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          dds_rst,
    output logic          dds_ce,
    output logic [TW-1:0] dds_tuning_word,
    output logic [PW-1:0] dds_start_phase
);

    typedef enum logic [1:0] {IDLE, LOAD, RAMP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] start_tw_q, start_tw_d;
    logic [TW-1:0] stop_tw_q, stop_tw_d;
    logic [TW-1:0] step_tw_q, step_tw_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] sweeps_q, sweeps_d;
    logic [CW-1:0] left_q, left_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [TW-1:0] tw_q, tw_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          dds_rst_q, dds_rst_d;
    logic          dds_ce_q, dds_ce_d;

    logic [TW:0]   tw_sum;
    logic [TW-1:0] tw_next;
    logic [DW-1:0] dwell_max;
    logic          dwell_last;

    // State and all outputs are registered together from their next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            start_tw_q  <= '0;
            stop_tw_q   <= '0;
            step_tw_q   <= '0;
            dwell_q     <= '0;
            sweeps_q    <= '0;
            left_q      <= '0;
            dwell_cnt_q <= '0;
            tw_q        <= '0;
            phase_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dds_rst_q   <= 1'b0;
            dds_ce_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_tw_q  <= start_tw_d;
            stop_tw_q   <= stop_tw_d;
            step_tw_q   <= step_tw_d;
            dwell_q     <= dwell_d;
            sweeps_q    <= sweeps_d;
            left_q      <= left_d;
            dwell_cnt_q <= dwell_cnt_d;
            tw_q        <= tw_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            dds_rst_q   <= dds_rst_d;
            dds_ce_q    <= dds_ce_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_tw_d  = start_tw_q;
        stop_tw_d   = stop_tw_q;
        step_tw_d   = step_tw_q;
        dwell_d     = dwell_q;
        sweeps_d    = sweeps_q;
        left_d      = left_q;
        dwell_cnt_d = dwell_cnt_q;
        tw_d        = tw_q;
        phase_d     = phase_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        dds_rst_d   = 1'b0;
        dds_ce_d    = 1'b0;

        // Step computed one bit wider so overflow past stop clamps instead of wrapping.
        tw_sum     = {1'b0, tw_q} + {1'b0, step_tw_q};
        tw_next    = (tw_sum > {1'b0, stop_tw_q}) ? stop_tw_q : tw_sum[TW-1:0];
        dwell_max  = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
        dwell_last = (dwell_cnt_q >= dwell_max);

        case (state_q)
            IDLE: begin
                if (start) begin
                    start_tw_d = cfg_start_tw;
                    stop_tw_d  = cfg_stop_tw;
                    step_tw_d  = cfg_step_tw;
                    dwell_d    = cfg_dwell;
                    sweeps_d   = cfg_sweeps;
                    if (cfg_step_tw == '0 || cfg_start_tw > cfg_stop_tw) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d     = LOAD;
                        busy_d      = 1'b1;
                        dds_rst_d   = 1'b1;
                        tw_d        = cfg_start_tw;
                        phase_d     = cfg_phase;
                        left_d      = cfg_sweeps;
                        dwell_cnt_d = '0;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = RAMP;
                    busy_d   = 1'b1;
                    dds_ce_d = 1'b1;
                end
            end
            RAMP: begin
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    busy_d   = 1'b1;
                    dds_ce_d = 1'b1;
                    if (!dwell_last) begin
                        dwell_cnt_d = dwell_cnt_q + DW'(1);
                    end else begin
                        dwell_cnt_d = '0;
                        if (tw_q != stop_tw_q) begin
                            tw_d = tw_next;
                        end else if (sweeps_q == '0 || left_q > CW'(1)) begin
                            // Repeat sweep without a phase reload so the output stays continuous.
                            tw_d = start_tw_q;
                            if (sweeps_q != '0) left_d = left_q - CW'(1);
                        end else begin
                            state_d  = IDLE;
                            busy_d   = 1'b0;
                            dds_ce_d = 1'b0;
                            done_d   = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign dds_rst         = dds_rst_q;
    assign dds_ce          = dds_ce_q;
    assign dds_tuning_word = tw_q;
    assign dds_start_phase = phase_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomized bench for dds_sweep_ctrl: expected tuning-word sequences come from a
// list-building model of the sweep rules; per-cycle status/word compared every cycle.
module tb_dds_sweep_ctrl;

    localparam int unsigned TW = 8;
    localparam int unsigned PW = 12;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [TW-1:0] cfg_start_tw;
    logic [TW-1:0] cfg_stop_tw;
    logic [TW-1:0] cfg_step_tw;
    logic [DW-1:0] cfg_dwell;
    logic [CW-1:0] cfg_sweeps;
    logic [PW-1:0] cfg_phase;
    logic          busy;
    logic          done;
    logic          err;
    logic          dds_rst;
    logic          dds_ce;
    logic [TW-1:0] dds_tuning_word;
    logic [PW-1:0] dds_start_phase;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int exp_last_tw;
    int exp_phase;

    logic [TW+4:0] obs_v;
    logic [TW+4:0] exp_v;

    dds_sweep_ctrl #(.TW(TW), .PW(PW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_start_tw(cfg_start_tw), .cfg_stop_tw(cfg_stop_tw), .cfg_step_tw(cfg_step_tw),
        .cfg_dwell(cfg_dwell), .cfg_sweeps(cfg_sweeps), .cfg_phase(cfg_phase),
        .busy(busy), .done(done), .err(err), .dds_rst(dds_rst), .dds_ce(dds_ce),
        .dds_tuning_word(dds_tuning_word), .dds_start_phase(dds_start_phase)
    );

    always #5 clk = ~clk;

    // {busy, done, err, dds_rst, dds_ce, tuning word}
    assign obs_v = {busy, done, err, dds_rst, dds_ce, dds_tuning_word};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_cfg();
        cfg_start_tw = TW'($urandom);
        cfg_stop_tw  = TW'($urandom);
        cfg_step_tw  = TW'($urandom);
        cfg_dwell    = DW'($urandom);
        cfg_sweeps   = CW'($urandom);
        cfg_phase    = PW'($urandom);
    endtask

    // Model: list every tuning word shown while dds_ce is high, sweep by sweep.
    task automatic build_exp(input int s, input int e, input int st, input int dw, input int sw);
        int reps;
        int d;
        int t;
        reps = (sw == 0) ? 3 : sw;
        d    = (dw == 0) ? 1 : dw;
        exp_q.delete();
        for (int r = 0; r < reps; r++) begin
            t = s;
            while (1) begin
                for (int k = 0; k < d; k++) exp_q.push_back(t);
                if (t == e) break;
                t = (t + st > e) ? e : t + st;
            end
        end
    endtask

    // abort_at: -1 none, -2 random index, >=0 abort sampled at end of that RAMP cycle.
    task automatic run_sweep(input string name, input int s, input int e, input int st,
                             input int dw, input int sw, input int abort_at, input bit abort_with_start);
        int ab;
        int ph;
        ph = int'($urandom_range(0, (1 << PW) - 1));
        cfg_start_tw = TW'(s);
        cfg_stop_tw  = TW'(e);
        cfg_step_tw  = TW'(st);
        cfg_dwell    = DW'(dw);
        cfg_sweeps   = CW'(sw);
        cfg_phase    = PW'(ph);
        start = 1'b1;
        abort = abort_with_start;
        tick();
        start = 1'b0;
        abort = 1'b0;
        scramble_cfg();
        build_exp(s, e, st, dw, sw);
        ab = abort_at;
        if (ab == -2) ab = int'($urandom_range(0, exp_q.size() - 1));

        exp_v = {5'b10010, TW'(s)};
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL %s load: got %h want %h", name, obs_v, exp_v);
        else n_pass++;
        exp_phase = ph;
        n_checks++;
        if (dds_start_phase !== PW'(ph)) $display("FAIL %s phase: got %h want %h", name, dds_start_phase, PW'(ph));
        else n_pass++;
        tick();

        for (int i = 0; i < exp_q.size(); i++) begin
            exp_v = {5'b10001, TW'(exp_q[i])};
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL %s ramp[%0d]: got %h want %h", name, i, obs_v, exp_v);
            else n_pass++;
            if (i == ab) begin
                abort = 1'b1;
                start = 1'b0;
                tick();
                abort = 1'b0;
                exp_last_tw = exp_q[i];
                exp_v = {5'b01000, TW'(exp_last_tw)};
                n_checks++;
                if (obs_v !== exp_v) $display("FAIL %s abort: got %h want %h", name, obs_v, exp_v);
                else n_pass++;
                tick();
                exp_v = {5'b00000, TW'(exp_last_tw)};
                n_checks++;
                if (obs_v !== exp_v) $display("FAIL %s post_abort: got %h want %h", name, obs_v, exp_v);
                else n_pass++;
                return;
            end
            // Stray start pulses during the sweep must be ignored.
            start = (i < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        start = 1'b0;
        exp_last_tw = e;
        exp_v = {5'b01000, TW'(e)};
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL %s done: got %h want %h", name, obs_v, exp_v);
        else n_pass++;
        tick();
        exp_v = {5'b00000, TW'(e)};
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL %s idle: got %h want %h", name, obs_v, exp_v);
        else n_pass++;
    endtask

    task automatic run_err(input string name, input int s, input int e, input int st);
        cfg_start_tw = TW'(s);
        cfg_stop_tw  = TW'(e);
        cfg_step_tw  = TW'(st);
        cfg_dwell    = DW'($urandom_range(0, 3));
        cfg_sweeps   = CW'($urandom_range(0, 3));
        cfg_phase    = PW'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_v = {5'b01100, TW'(exp_last_tw)};
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL %s err_pulse: got %h want %h", name, obs_v, exp_v);
        else n_pass++;
        n_checks++;
        if (dds_start_phase !== PW'(exp_phase)) $display("FAIL %s err_phase: got %h want %h", name, dds_start_phase, PW'(exp_phase));
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_v = {5'b00000, TW'(exp_last_tw)};
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL %s err_idle[%0d]: got %h want %h", name, k, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        scramble_cfg();
        repeat (2) @(posedge clk);
        #1;
        exp_v = '0;
        n_checks++;
        if (obs_v !== exp_v || dds_start_phase !== '0) $display("FAIL reset: got %h/%h want 0", obs_v, dds_start_phase);
        else n_pass++;
        // Start asserted during reset must not launch anything.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL reset_release: got %h want 0", obs_v);
        else n_pass++;
        exp_last_tw = 0;
        exp_phase   = 0;
    endtask

    task automatic test_directed();
        run_sweep("dwell3", 10, 40, 10, 3, 1, -1, 1'b0);
        run_sweep("clamp25", 0, 25, 10, 1, 1, -1, 1'b0);
        run_sweep("nowrap", 250, 255, 10, 0, 1, -1, 1'b0);
        run_sweep("two_sweeps", 5, 15, 5, 2, 2, -1, 1'b0);
    endtask

    task automatic test_errors();
        run_err("step0", 10, 40, 0);
        run_err("start_gt_stop", 50, 40, 5);
    endtask

    task automatic test_abort();
        run_sweep("abort4", 10, 40, 10, 3, 1, 3, 1'b0);
        run_sweep("continuous", 0, 30, 10, 1, 0, 9, 1'b0);
        run_sweep("abort_with_start", 20, 60, 20, 1, 1, -1, 1'b1);
        run_sweep("abort_first", 3, 9, 3, 0, 1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_ramp();
        cfg_start_tw = 8'd10; cfg_stop_tw = 8'd40; cfg_step_tw = 8'd10;
        cfg_dwell = 16'd3; cfg_sweeps = 8'd1; cfg_phase = 12'h5a5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_v !== '0 || dds_start_phase !== '0) $display("FAIL reset_mid: got %h/%h want 0", obs_v, dds_start_phase);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_last_tw = 0;
        exp_phase   = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs_v !== '0) $display("FAIL reset_mid_idle[%0d]: got %h want 0", k, obs_v);
            else n_pass++;
        end
        run_sweep("after_reset", 10, 40, 10, 3, 1, -1, 1'b0);
    endtask

    task automatic test_random();
        int s, e, st, dw, sw, mode;
        for (int n = 0; n < 30; n++) begin
            mode = int'($urandom_range(0, 5));
            if (mode == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    s = int'($urandom_range(0, 200));
                    e = s + int'($urandom_range(0, 55));
                    run_err("rnd_err_step", s, e, 0);
                end else begin
                    s = int'($urandom_range(1, 255));
                    e = int'($urandom_range(0, s - 1));
                    run_err("rnd_err_order", s, e, int'($urandom_range(0, 255)));
                end
            end else begin
                s  = int'($urandom_range(0, 199));
                e  = (mode == 5) ? 255 : s + int'($urandom_range(0, 55));
                st = (mode == 5) ? int'($urandom_range(1, 255)) : int'($urandom_range(1, 20));
                dw = int'($urandom_range(0, 3));
                sw = int'($urandom_range(0, 3));
                run_sweep("rnd", s, e, st, dw, sw,
                          (sw == 0 || $urandom_range(0, 3) == 0) ? -2 : -1,
                          1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_abort();
        test_reset_mid_ramp();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL provide parameter TW, default 8: tuning word width, matching the driven dds.
REQ-002 SHALL provide parameter PW, default 12: phase accumulator width, matching the driven dds.
REQ-003 SHALL provide parameter DW, default 16: dwell counter width.
REQ-004 SHALL provide parameter CW, default 8: sweep repeat count width.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk in 1 rising-edge clock; rst_n in 1 asynchronous active-low reset.
REQ-006 SHALL provide the following inputs:
- start in 1: begin sweep, sampled in IDLE only.
- abort in 1: terminate sweep.
- cfg_start_tw in TW.
- cfg_stop_tw in TW.
- cfg_step_tw in TW.
- cfg_dwell in DW: cycles per step; 0 is treated as 1.
- cfg_sweeps in CW: sweep count; 0 means continuous.
- cfg_phase in PW: phase reload value.
REQ-007 SHALL provide the following outputs:
- busy out 1.
- done out 1: one-cycle pulse.
- err out 1: one-cycle pulse, coincident with done.
- dds_rst out 1: phase-reload pulse to the dds.
- dds_ce out 1.
- dds_tuning_word out TW.
- dds_start_phase out PW.

Function
REQ-008 SHALL implement FSM states IDLE, LOAD, RAMP.
REQ-009 SHALL, in IDLE with start=1, latch all cfg_* inputs; later cfg_* changes are ignored until the next IDLE.
REQ-010 SHALL, in IDLE on start, go to IDLE with done=1, err=1 for one cycle and never assert dds_ce if cfg_step_tw==0 or cfg_start_tw>cfg_stop_tw (unsigned).
REQ-011 SHALL otherwise go to LOAD, then assert dds_rst=1 for exactly one cycle, driving dds_start_phase=latched cfg_phase, dds_tuning_word=latched start_tw and dds_ce=0.
REQ-012 SHALL go LOAD->RAMP unconditionally; dds_ce=1 in every RAMP cycle and 0 in every other state.
REQ-013 SHALL hold dds_tuning_word for max(dwell,1) RAMP cycles at each step value.
REQ-014 SHALL compute the next step in TW+1 bits as tw+step; if the result exceeds stop_tw, the next value SHALL be stop_tw (clamp, no wrap).
REQ-015 SHALL end the sweep after the dwell at tw==stop_tw completes.
REQ-016 SHALL, at sweep end when remaining sweeps >1 or cfg_sweeps==0, stay in RAMP and reload tw=start_tw on the next cycle without dds_rst, keeping phase continuous.
REQ-017 SHALL, at the end of the final sweep, go to IDLE with done=1 for one cycle and err=0.
REQ-018 SHALL drive busy=1 in LOAD and RAMP and busy=0 in IDLE.
REQ-019 SHALL, on abort=1 in LOAD or RAMP, go to IDLE next cycle with dds_ce=0, done=1 and err=0; abort SHALL take priority over step and sweep-end events in the same cycle.
REQ-020 SHALL ignore abort in IDLE; abort and start high together in IDLE SHALL be treated as start.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL, in IDLE, hold dds_tuning_word at its last value.
REQ-023 SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-024 SHALL give latency from start sampled at edge N: dds_rst high in cycle N+1, first dds_ce high in cycle N+2.

Reset
REQ-025 SHALL, while rst_n=0 and asynchronously, force state=IDLE and busy, done, err, dds_rst, dds_ce=0.
REQ-026 SHALL, while rst_n=0, force dds_tuning_word=0, dds_start_phase=0 and all counters to 0.
REQ-027 SHALL leave IDLE no earlier than the first rising clk edge after rst_n deassertion, and only on start.
REQ-028 SHALL, on reset mid-sweep, drop dds_ce immediately and not pulse done.

Verification
REQ-029 SHALL cover: start=10, stop=40, step=10, dwell=3, sweeps=1 -> dds_rst 1 cycle; then tw 10,10,10,20,20,20,30,30,30,40,40,40 with dds_ce high 12 cycles; done 1 cycle after the last; busy low after.
REQ-030 SHALL cover: start=0, stop=25, step=10, dwell=1 -> tw 0,10,20,25; done; no value >25.
REQ-031 SHALL cover: TW=8, start=250, stop=255, step=10, dwell=0 -> tw 250,255; no wrap to 4; dwell 1 per step.
REQ-032 SHALL cover: start=5, stop=15, step=5, dwell=2, sweeps=2 -> single dds_rst; tw 5,5,10,10,15,15,5,5,10,10,15,15 contiguous dds_ce; one done.
REQ-033 SHALL cover: step=0 or start>stop -> done and err pulse together 1 cycle after start; dds_ce and dds_rst never high.
REQ-034 SHALL cover: abort in the 4th RAMP cycle and, separately, rst_n low mid-RAMP -> abort: dds_ce low next cycle, done=1, err=0; reset: outputs 0 immediately, no done; a following start runs a full normal sweep.
